// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the ingress-to-egress pop scheduler: FSM encodings
// and small helpers used to derive constants and decode the class field.
package fifo_sched_pkg;

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } sched_state_t;

    // Reset value of the round-robin pointer: the last ingress index, so
    // that the first scan after reset starts at ingress 0.
    function automatic int reset_rr_ptr(input int n);
        return n - 1;
    endfunction

    // Class of a word: its top cw bits (word is zero-extended to 32 bits).
    function automatic int class_of(input logic [31:0] word, input int dw, input int cw);
        logic [31:0] mask;
        mask = (32'd1 << cw) - 32'd1;
        return int'((word >> (dw - cw)) & mask);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter: grants the first requester found
// scanning upward from ptr+1 and wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    // Scan from the slot after the last winner; the first request seen wins.
    always_comb begin
        logic found;
        int   idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_pop_scheduler.sv
// Pop scheduler between ingress and egress FIFOs: loads thresholds during
// INIT, pops ingress FIFOs round-robin while no egress is almost full, and
// forwards each popped word one cycle later to the egress chosen by its class.
module fifo_pop_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int DW    = 6,
    parameter int CW    = 2,
    parameter int TW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [TW-1:0]        umbral_almost_full_in,
    input  logic [TW-1:0]        umbral_almost_empty_in,
    input  logic [N_IN-1:0]      in_fifo_empty,
    input  logic [N_IN-1:0]      in_fifo_error,
    input  logic [N_IN*DW-1:0]   in_data,
    input  logic [N_IN-1:0]      in_valid,
    input  logic [N_OUT-1:0]     out_almost_full,
    input  logic [N_OUT-1:0]     out_fifo_error,
    output logic [N_IN-1:0]      pop,
    output logic [N_OUT-1:0]     push,
    output logic [DW-1:0]        data_out,
    output logic [TW-1:0]        umbral_almost_full_out,
    output logic [TW-1:0]        umbral_almost_empty_out,
    output logic [4:0]           state,
    output logic                 idle_out,
    output logic                 error_out
);

    localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [PW-1:0] RST_PTR = PW'(reset_rr_ptr(N_IN));

    sched_state_t    r_state;
    sched_state_t    w_next_state;
    logic [PW-1:0]   r_rr_ptr;
    logic            r_push_valid;
    logic [DW-1:0]   r_data;
    logic [TW-1:0]   r_thr_full;
    logic [TW-1:0]   r_thr_empty;

    logic [N_IN-1:0] w_grant;
    logic [PW-1:0]   w_grant_idx;
    logic [N_IN-1:0] w_pop;
    logic            w_pop_en;
    logic            w_pop_any;
    logic            w_any_error;
    logic [DW-1:0]   w_sel_word;
    logic            w_sel_valid;
    logic [CW-1:0]   w_class;

    rr_arbiter #(
        .N  (N_IN),
        .PW (PW)
    ) u_arb (
        .req       (~in_fifo_empty),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_pop_en    = (r_state == ST_ACTIVE) && !(|out_almost_full) && !init;
    assign w_pop       = w_pop_en ? w_grant : '0;
    assign w_pop_any   = |w_pop;
    assign w_any_error = (|in_fifo_error) || (|out_fifo_error);
    assign w_class     = CW'(class_of(32'(r_data), DW, CW));

    // Select the granted ingress word and valid; other ingress buses are ignored.
    always_comb begin
        w_sel_word  = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (w_grant[i]) begin
                w_sel_word  = in_data[i*DW +: DW];
                w_sel_valid = in_valid[i];
            end
        end
    end

    // Next-state logic; errors dominate init, which dominates normal flow.
    // Pops are already blocked while init=1, so the only transfer still in
    // flight when leaving ACTIVE for INIT is the push on the outputs now.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RESET:  w_next_state = ST_INIT;
            ST_ERROR:  w_next_state = ST_ERROR;
            default: begin
                if (w_any_error) begin
                    w_next_state = ST_ERROR;
                end else begin
                    case (r_state)
                        ST_INIT: begin
                            if (!init) w_next_state = ST_IDLE;
                        end
                        ST_IDLE: begin
                            if (init)                     w_next_state = ST_INIT;
                            else if (!(&in_fifo_empty))   w_next_state = ST_ACTIVE;
                        end
                        ST_ACTIVE: begin
                            if (init && !w_pop_any)                    w_next_state = ST_INIT;
                            else if ((&in_fifo_empty) && !w_pop_any)   w_next_state = ST_IDLE;
                        end
                        default: w_next_state = r_state;
                    endcase
                end
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_RESET;
        else       r_state <= w_next_state;
    end

    // Pointer, one-stage datapath register and threshold latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= RST_PTR;
            r_push_valid <= 1'b0;
            r_data       <= '0;
            r_thr_full   <= '0;
            r_thr_empty  <= '0;
        end else begin
            r_push_valid <= w_pop_any && w_sel_valid;
            if (w_pop_any) begin
                r_rr_ptr <= w_grant_idx;
                if (w_sel_valid) r_data <= w_sel_word;
            end
            if (r_state == ST_INIT && init) begin
                r_thr_full  <= umbral_almost_full_in;
                r_thr_empty <= umbral_almost_empty_in;
            end
        end
    end

    assign pop                     = w_pop;
    assign push                    = (r_push_valid && r_state != ST_ERROR) ? (N_OUT'(1) << w_class) : '0;
    assign data_out                = r_data;
    assign umbral_almost_full_out  = r_thr_full;
    assign umbral_almost_empty_out = r_thr_empty;
    assign state                   = r_state;
    assign idle_out                = (r_state == ST_IDLE);
    assign error_out               = (r_state == ST_ERROR);

endmodule

// File: tb/tb_fifo_pop_scheduler.sv
// Self-checking bench for fifo_pop_scheduler: a directed vector table, a few
// hand-written corner sequences, and a randomized phase checked against a
// queue-based reference model.
module tb_fifo_pop_scheduler;

    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int DW    = 6;
    localparam int CW    = 2;
    localparam int TW    = 4;

    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;
    localparam int M_ERROR  = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                init;
    logic [TW-1:0]       umbral_almost_full_in;
    logic [TW-1:0]       umbral_almost_empty_in;
    logic [N_IN-1:0]     in_fifo_empty;
    logic [N_IN-1:0]     in_fifo_error;
    logic [N_IN*DW-1:0]  in_data;
    logic [N_IN-1:0]     in_valid;
    logic [N_OUT-1:0]    out_almost_full;
    logic [N_OUT-1:0]    out_fifo_error;
    logic [N_IN-1:0]     pop;
    logic [N_OUT-1:0]    push;
    logic [DW-1:0]       data_out;
    logic [TW-1:0]       umbral_almost_full_out;
    logic [TW-1:0]       umbral_almost_empty_out;
    logic [4:0]          state;
    logic                idle_out;
    logic                error_out;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state.
    int            mState;
    int            mPtr;
    logic [TW-1:0] mThrFull;
    logic [TW-1:0] mThrEmpty;
    logic [DW-1:0] mData;
    logic [DW-1:0] mPending[$];

    typedef struct {
        logic          rst;
        logic          ini;
        logic [3:0]    empty;
        logic [4:0]    expState;
        logic [3:0]    expPop;
        logic [3:0]    expPush;
        logic [5:0]    expData;
        logic [3:0]    expThrF;
        logic [3:0]    expThrE;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    fifo_pop_scheduler #(
        .N_IN (N_IN), .N_OUT (N_OUT), .DW (DW), .CW (CW), .TW (TW)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .init                    (init),
        .umbral_almost_full_in   (umbral_almost_full_in),
        .umbral_almost_empty_in  (umbral_almost_empty_in),
        .in_fifo_empty           (in_fifo_empty),
        .in_fifo_error           (in_fifo_error),
        .in_data                 (in_data),
        .in_valid                (in_valid),
        .out_almost_full         (out_almost_full),
        .out_fifo_error          (out_fifo_error),
        .pop                     (pop),
        .push                    (push),
        .data_out                (data_out),
        .umbral_almost_full_out  (umbral_almost_full_out),
        .umbral_almost_empty_out (umbral_almost_empty_out),
        .state                   (state),
        .idle_out                (idle_out),
        .error_out               (error_out)
    );

    // Compare one observed value with the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs shortly after the rising edge.
    task automatic applyStimulus(input logic rst, input logic ini,
                                 input logic [TW-1:0] thrF, input logic [TW-1:0] thrE,
                                 input logic [N_IN-1:0] empty, input logic [N_IN-1:0] inErr,
                                 input logic [N_IN*DW-1:0] dat, input logic [N_IN-1:0] val,
                                 input logic [N_OUT-1:0] af, input logic [N_OUT-1:0] outErr);
        @(posedge clk);
        #1;
        reset                  = rst;
        init                   = ini;
        umbral_almost_full_in  = thrF;
        umbral_almost_empty_in = thrE;
        in_fifo_empty          = empty;
        in_fifo_error          = inErr;
        in_data                = dat;
        in_valid               = val;
        out_almost_full        = af;
        out_fifo_error         = outErr;
    endtask

    // Ingress index the model grants this cycle, or -1.
    function automatic int modelGrant();
        if (mState != M_ACTIVE || (|out_almost_full) || init) return -1;
        for (int k = 1; k <= N_IN; k++) begin
            int idx;
            idx = (mPtr + k) % N_IN;
            if (!in_fifo_empty[idx]) return idx;
        end
        return -1;
    endfunction

    // Compare every DUT output with the model's view of the current cycle.
    task automatic checkAgainstModel();
        int            g;
        logic [3:0]    expPop;
        logic [3:0]    expPush;
        g       = modelGrant();
        expPop  = (g >= 0) ? 4'(1 << g) : 4'h0;
        expPush = 4'h0;
        if (mPending.size() > 0 && mState != M_ERROR)
            expPush = 4'(1 << (mPending[0] >> (DW - CW)));
        checkOutput("model_pop", 32'(pop), 32'(expPop));
        checkOutput("model_push", 32'(push), 32'(expPush));
        checkOutput("model_data_out", 32'(data_out), 32'(mData));
        checkOutput("model_state", 32'(state), 32'(1 << mState));
        checkOutput("model_idle_out", 32'(idle_out), 32'(mState == M_IDLE));
        checkOutput("model_error_out", 32'(error_out), 32'(mState == M_ERROR));
        checkOutput("model_thr_full", 32'(umbral_almost_full_out), 32'(mThrFull));
        checkOutput("model_thr_empty", 32'(umbral_almost_empty_out), 32'(mThrEmpty));
    endtask

    // Advance the model across the coming clock edge using the current inputs.
    task automatic modelAdvance();
        int g;
        g = modelGrant();
        if (reset) begin
            mState    = M_RESET;
            mPtr      = N_IN - 1;
            mThrFull  = '0;
            mThrEmpty = '0;
            mData     = '0;
            mPending.delete();
            return;
        end
        mPending.delete();
        if (g >= 0) begin
            mPtr = g;
            if (in_valid[g]) begin
                mData = in_data[g*DW +: DW];
                mPending.push_back(mData);
            end
        end
        if (mState == M_INIT && init) begin
            mThrFull  = umbral_almost_full_in;
            mThrEmpty = umbral_almost_empty_in;
        end
        if (mState == M_RESET) begin
            mState = M_INIT;
        end else if (mState != M_ERROR) begin
            if ((|in_fifo_error) || (|out_fifo_error)) mState = M_ERROR;
            else if (mState == M_INIT) begin
                if (!init) mState = M_IDLE;
            end else if (mState == M_IDLE) begin
                if (init) mState = M_INIT;
                else if (in_fifo_empty != 4'hF) mState = M_ACTIVE;
            end else if (mState == M_ACTIVE) begin
                if (init) mState = M_INIT;
                else if (in_fifo_empty == 4'hF && g < 0) mState = M_IDLE;
            end
        end
    endtask

    // Mid-cycle model check followed by the model's clock step.
    task automatic modelCycle();
        #4;
        checkAgainstModel();
        modelAdvance();
    endtask

    initial begin
        mState    = M_RESET;
        mPtr      = N_IN - 1;
        mThrFull  = '0;
        mThrEmpty = '0;
        mData     = '0;

        //            rst   ini   empty  state      pop    push   data   thrF thrE
        vecs[0]  = '{1'b1, 1'b0, 4'hF, 5'b00001, 4'h0, 4'h0, 6'h00, 4'd0, 4'd0};
        vecs[1]  = '{1'b0, 1'b1, 4'hF, 5'b00001, 4'h0, 4'h0, 6'h00, 4'd0, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 4'hF, 5'b00010, 4'h0, 4'h0, 6'h00, 4'd0, 4'd0};
        vecs[3]  = '{1'b0, 1'b1, 4'hF, 5'b00010, 4'h0, 4'h0, 6'h00, 4'd6, 4'd2};
        vecs[4]  = '{1'b0, 1'b0, 4'hF, 5'b00010, 4'h0, 4'h0, 6'h00, 4'd6, 4'd2};
        vecs[5]  = '{1'b0, 1'b0, 4'hF, 5'b00100, 4'h0, 4'h0, 6'h00, 4'd6, 4'd2};
        vecs[6]  = '{1'b0, 1'b0, 4'h0, 5'b00100, 4'h0, 4'h0, 6'h00, 4'd6, 4'd2};
        vecs[7]  = '{1'b0, 1'b0, 4'h0, 5'b01000, 4'h1, 4'h0, 6'h00, 4'd6, 4'd2};
        vecs[8]  = '{1'b0, 1'b0, 4'h0, 5'b01000, 4'h2, 4'h4, 6'h20, 4'd6, 4'd2};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 5'b01000, 4'h4, 4'h4, 6'h21, 4'd6, 4'd2};
        vecs[10] = '{1'b0, 1'b0, 4'h0, 5'b01000, 4'h8, 4'h4, 6'h22, 4'd6, 4'd2};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 5'b01000, 4'h1, 4'h4, 6'h23, 4'd6, 4'd2};
        vecs[12] = '{1'b0, 1'b0, 4'hF, 5'b01000, 4'h0, 4'h4, 6'h20, 4'd6, 4'd2};
        vecs[13] = '{1'b0, 1'b0, 4'hF, 5'b00100, 4'h0, 4'h0, 6'h20, 4'd6, 4'd2};

        // Bring the DUT out of its power-up state.
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'hF, 4'h0, '0, 4'hF, 4'h0, 4'h0);
        #4;
        modelAdvance();

        // Directed table: reset, threshold load, IDLE, then round-robin pops.
        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].ini, 4'd6, 4'd2, vecs[v].empty, 4'h0,
                          {6'h23, 6'h22, 6'h21, 6'h20}, 4'hF, 4'h0, 4'h0);
            #4;
            checkOutput($sformatf("vec%0d_state", v), 32'(state), 32'(vecs[v].expState));
            checkOutput($sformatf("vec%0d_pop", v), 32'(pop), 32'(vecs[v].expPop));
            checkOutput($sformatf("vec%0d_push", v), 32'(push), 32'(vecs[v].expPush));
            checkOutput($sformatf("vec%0d_data", v), 32'(data_out), 32'(vecs[v].expData));
            checkOutput($sformatf("vec%0d_thr_full", v), 32'(umbral_almost_full_out), 32'(vecs[v].expThrF));
            checkOutput($sformatf("vec%0d_thr_empty", v), 32'(umbral_almost_empty_out), 32'(vecs[v].expThrE));
            modelAdvance();
        end

        // Only ingress 2 holds a word; it lands in egress 3, then back to IDLE.
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'b1011, 4'h0, {6'h00, 6'h35, 6'h00, 6'h00}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'b1011, 4'h0, {6'h00, 6'h35, 6'h00, 6'h00}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        checkOutput("single_pop", 32'(pop), 32'h4);
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'hF, 4'h0, {6'h00, 6'h35, 6'h00, 6'h00}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        checkOutput("single_push", 32'(push), 32'h8);
        checkOutput("single_data", 32'(data_out), 32'h35);
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'hF, 4'h0, {6'h00, 6'h35, 6'h00, 6'h00}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        checkOutput("single_back_to_idle", 32'(state), 32'h04);

        // Almost-full mid-stream: granted word still pushed, pops resume in order.
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'h0, 4'h0, {6'h1A, 6'h05, 6'h0A, 6'h11}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'h0, 4'h0, {6'h1A, 6'h05, 6'h0A, 6'h11}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        checkOutput("af_pop_before", 32'(pop), 32'h8);
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'h0, 4'h0, {6'h1A, 6'h05, 6'h0A, 6'h11}, 4'hF, 4'b0010, 4'h0);
        modelCycle();
        checkOutput("af_pop_blocked", 32'(pop), 32'h0);
        checkOutput("af_push_kept", 32'(push), 32'h2);
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'h0, 4'h0, {6'h1A, 6'h05, 6'h0A, 6'h11}, 4'hF, 4'b0010, 4'h0);
        modelCycle();
        checkOutput("af_push_once", 32'(push), 32'h0);
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'h0, 4'h0, {6'h1A, 6'h05, 6'h0A, 6'h11}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        checkOutput("af_resume_pop", 32'(pop), 32'h1);

        // Reset while a pop is granted: the pending push is dropped.
        applyStimulus(1'b1, 1'b0, 4'd6, 4'd2, 4'h0, 4'h0, {6'h1A, 6'h05, 6'h0A, 6'h11}, 4'hF, 4'h0, 4'h0);
        #4;
        modelAdvance();
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'h0, 4'h0, {6'h1A, 6'h05, 6'h0A, 6'h11}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        checkOutput("rst_state", 32'(state), 32'h01);
        checkOutput("rst_no_push", 32'(push), 32'h0);
        applyStimulus(1'b0, 1'b1, 4'd9, 4'd3, 4'h0, 4'h0, {6'h1A, 6'h05, 6'h0A, 6'h11}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        applyStimulus(1'b0, 1'b0, 4'd9, 4'd3, 4'h0, 4'h0, {6'h1A, 6'h05, 6'h0A, 6'h11}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        checkOutput("reinit_thr_full", 32'(umbral_almost_full_out), 32'h9);
        applyStimulus(1'b0, 1'b0, 4'd9, 4'd3, 4'h0, 4'h0, {6'h1A, 6'h05, 6'h0A, 6'h11}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        applyStimulus(1'b0, 1'b0, 4'd9, 4'd3, 4'h0, 4'h0, {6'h1A, 6'h05, 6'h0A, 6'h11}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        checkOutput("reinit_first_grant", 32'(pop), 32'h1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            logic             rRst;
            logic             rIni;
            logic [N_IN-1:0]  rEmpty;
            logic [N_OUT-1:0] rAf;
            logic [N_IN-1:0]  rVal;
            rRst   = ($urandom_range(0, 99) == 0);
            rIni   = ($urandom_range(0, 29) == 0);
            rEmpty = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            rAf    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            rVal   = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF;
            applyStimulus(rRst, rIni, 4'($urandom), 4'($urandom), rEmpty, 4'h0,
                          24'($urandom), rVal, rAf, 4'h0);
            modelCycle();
        end

        // Error during ACTIVE: sticky ERROR until reset.
        applyStimulus(1'b1, 1'b0, 4'd6, 4'd2, 4'hF, 4'h0, '0, 4'hF, 4'h0, 4'h0);
        modelCycle();
        applyStimulus(1'b0, 1'b1, 4'd6, 4'd2, 4'hF, 4'h0, '0, 4'hF, 4'h0, 4'h0);
        modelCycle();
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'hF, 4'h0, '0, 4'hF, 4'h0, 4'h0);
        modelCycle();
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'h0, 4'h0, {6'h3F, 6'h2A, 6'h15, 6'h01}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'h0, 4'b1000, {6'h3F, 6'h2A, 6'h15, 6'h01}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        checkOutput("err_pre_state", 32'(state), 32'h08);
        applyStimulus(1'b0, 1'b1, 4'd6, 4'd2, 4'h0, 4'h0, {6'h3F, 6'h2A, 6'h15, 6'h01}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        checkOutput("err_state", 32'(state), 32'h10);
        checkOutput("err_pop", 32'(pop), 32'h0);
        checkOutput("err_push", 32'(push), 32'h0);
        checkOutput("err_flag", 32'(error_out), 32'h1);
        applyStimulus(1'b0, 1'b1, 4'd6, 4'd2, 4'h0, 4'h0, {6'h3F, 6'h2A, 6'h15, 6'h01}, 4'hF, 4'h0, 4'h0);
        modelCycle();
        checkOutput("err_sticky", 32'(state), 32'h10);
        applyStimulus(1'b1, 1'b0, 4'd6, 4'd2, 4'h0, 4'h0, '0, 4'hF, 4'h0, 4'h0);
        modelCycle();
        applyStimulus(1'b0, 1'b0, 4'd6, 4'd2, 4'hF, 4'h0, '0, 4'hF, 4'h0, 4'h0);
        modelCycle();
        checkOutput("err_reset_exit", 32'(state), 32'h01);
        checkOutput("err_reset_flag", 32'(error_out), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fifo_pop_scheduler.md
Name: fifo_pop_scheduler

Overview:
Controller that sits between N_IN ingress fifo_c instances and N_OUT egress fifo_c instances. It sequences configuration (threshold load), issues at most one pop per cycle to the ingress FIFOs in round-robin order, and routes each popped word to the egress FIFO selected by its class bits. Ingress pops pause while any egress FIFO is almost full. Any FIFO error freezes the block in a sticky error state.

Parameters:
N_IN, 4, number of ingress FIFOs (2..8)
N_OUT, 4, number of egress FIFOs (must equal 2**CW)
DW, 6, data word width
CW, 2, class width; class = data[DW-1:DW-CW]
TW, 4, threshold width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
init  in  1  1 = enter/hold INIT and load thresholds
umbral_almost_full_in  in  TW  almost-full threshold to distribute
umbral_almost_empty_in  in  TW  almost-empty threshold to distribute
in_fifo_empty  in  N_IN  empty flags of the ingress FIFOs
in_fifo_error  in  N_IN  error flags of the ingress FIFOs
in_data  in  N_IN*DW  ingress data_out buses, word i at [i*DW +: DW]
in_valid  in  N_IN  ingress valid_out
out_almost_full  in  N_OUT  almost_empty_full flags of the egress FIFOs
out_fifo_error  in  N_OUT  error flags of the egress FIFOs
pop  out  N_IN  one-hot (or zero) pop strobes to the ingress FIFOs
push  out  N_OUT  one-hot (or zero) push strobes to the egress FIFOs
data_out  out  DW  word driven to all egress data_in
umbral_almost_full_out  out  TW  latched threshold to all FIFOs
umbral_almost_empty_out  out  TW  latched threshold to all FIFOs
state  out  5  one-hot FSM state
idle_out  out  1  1 in IDLE
error_out  out  1  1 in ERROR

Behaviour:
- Reset (reset=1 at a clk edge): state=RESET (5'b00001). pop=0, push=0, data_out=0, thresholds_out=0, idle_out=0, error_out=0. RR pointer is set to N_IN-1, so ingress 0 has first priority.
- FSM states, one-hot: RESET=00001, INIT=00010, IDLE=00100, ACTIVE=01000, ERROR=10000.
  - RESET -> INIT on the first edge with reset=0.
  - INIT: each cycle with init=1, latch umbral_*_in into umbral_*_out. When init=0, go to IDLE (the thresholds keep their last latched value).
  - IDLE: go to ACTIVE if any in_fifo_empty bit is 0. Go to INIT if init=1. idle_out=1.
  - ACTIVE: go to IDLE when all in_fifo_empty=1 and no transfer is in flight. Go to INIT if init=1, but only after the in-flight push completes.
  - From any state except RESET: |in_fifo_error or |out_fifo_error -> ERROR.
  - ERROR is sticky; only reset exits it. error_out=1. pop and push are forced to 0.
  - Priority of transitions: reset > error > init > others.
- Pop issue:
  - Allowed only in ACTIVE, with ~|out_almost_full and init=0.
  - The grant goes to the first index with in_fifo_empty=0, scanning from rr_ptr+1 upward and wrapping modulo N_IN.
  - pop is combinational from the registered rr_ptr and the current flags; at most one bit is set.
  - On a grant, rr_ptr <= granted index at the next edge.
- Datapath (1-cycle latency):
  - Pop at cycle t: the ingress FIFO returns the word with in_valid=1 in the same cycle t.
  - The block registers the word: at t+1, data_out = word and push[word class] = 1, for one cycle only.
  - Only the granted ingress's in_valid and in_data are considered.
- Boundaries:
  - A pop granted in cycle t is never cancelled. If almost_full rises at t+1, the t+1 push still happens; pops stop from t+1. Egress thresholds must leave at least 1 entry of slack.
  - If the granted in_valid=0 (the FIFO underflowed), no push occurs; the ingress error flag then drives ERROR.
  - Back-to-back pops with no bubbles are allowed; throughput is 1 word/cycle.
  - reset asserted mid-transfer drops the pending push, with no partial outputs.
  - N_IN=1 degenerates to always granting index 0.

Decomposition:
- Package fifo_sched_pkg: state encodings, the RESET_RR_PTR constant, and a class-extract function.
- Sub-module rr_arbiter: parameter N, inputs req[N] and ptr, outputs grant[N] one-hot and grant_idx. It is purely combinational; the FSM, pointer register and datapath register stay in fifo_pop_scheduler.

Test Plan:
- Reset, then init=1 with thresholds 6/2 for 2 cycles, then init=0 -> state sequence RESET→INIT→IDLE, umbral_almost_full_out=6, umbral_almost_empty_out=2, pop=0.
- in_fifo_empty=4'b0000 held continuously, all words class 2 -> pop cycles 0001,0010,0100,1000,0001…; push=0100 every cycle from the 2nd cycle onward; data_out equals the prior cycle's granted word.
- Only ingress 2 non-empty with word 6'b11_0101 -> pop=0100, next cycle push=1000 and data_out=6'h35; ACTIVE→IDLE after the last push.
- out_almost_full[1]=1 mid-stream -> pop=0 from that cycle; the already-granted word is still pushed once; pops resume in RR order from rr_ptr+1 when almost_full clears.
- in_fifo_error[3]=1 during ACTIVE -> next state ERROR, pop=push=0, error_out=1; stays in ERROR with init=1; reset returns to RESET.
- reset=1 in the same cycle as a pop grant -> no push the following cycle, rr_ptr=N_IN-1, so the first grant after re-init goes to ingress 0.
